// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and enums for the fetch/data arbiter in front of the single-port
// tri-state RAM.
package mem_port_arbiter_pkg;

    localparam int unsigned DWIDTH   = 8;
    localparam int unsigned AWIDTH   = 6;
    localparam int unsigned MEMDEPTH = 1 << AWIDTH;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StWr   = 2'd2
    } state_e;

    typedef enum logic {
        PortIf = 1'b0,
        PortD  = 1'b1
    } port_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM-control signals of the arbiter. The master side is the
// requester/RAM environment; the slave side is the arbiter.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DW = DWIDTH,
    parameter int unsigned AW = AWIDTH
) ();

    logic          ifReq;
    logic [AW-1:0] ifAddr;
    logic          ifGnt;
    logic          ifValid;
    logic [DW-1:0] ifData;

    logic          dReq;
    logic          dWe;
    logic [AW-1:0] dAddr;
    logic [DW-1:0] dWdata;
    logic          dGnt;
    logic          dValid;
    logic [DW-1:0] dRdata;

    logic [AW-1:0] memAddr;
    logic          memRdEn;
    logic          memWrEn;

    modport master (
        output ifReq, ifAddr, dReq, dWe, dAddr, dWdata,
        input  ifGnt, ifValid, ifData, dGnt, dValid, dRdata, memAddr, memRdEn, memWrEn
    );

    modport slave (
        input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata,
        output ifGnt, ifValid, ifData, dGnt, dValid, dRdata, memAddr, memRdEn, memWrEn
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester arbiter: a lone requester always wins; on a conflict the prio flop picks
// the winner and then toggles. Bit 0 is the fetch port, bit 1 the data port.
module mem_port_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 1 = data port wins the next conflict
    logic prio_q, prio_d;

    always_comb begin
        gnt    = 2'b00;
        prio_d = prio_q;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    gnt    = prio_q ? 2'b10 : 2'b01;
                    prio_d = ~prio_q;
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b1;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto a single-port RAM with a shared
// bidirectional data bus; one access per two cycles, IDLE always between accesses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DW = DWIDTH,
    parameter int unsigned AW = AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    inout  wire  [DW-1:0]     memData
);

    state_e        state_q, state_d;
    port_e         port_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_data_q, d_rdata_q;
    logic          if_valid_q, d_valid_q;
    logic [1:0]    gnt;
    logic          arb_en;

    // Reset masks grants so a request seen alongside rst is never accepted.
    assign arb_en = (state_q == StIdle) && !rst;

    mem_port_arbiter_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({bus.dReq, bus.ifReq}),
        .gnt (gnt)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (gnt[1]) begin
                    state_d = bus.dWe ? StWr : StRd;
                end else if (gnt[0]) begin
                    state_d = StRd;
                end
            end
            StRd:    state_d = StIdle;
            StWr:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            port_q     <= PortD;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_data_q  <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= (state_q == StRd) && (port_q == PortIf);
            d_valid_q  <= ((state_q == StRd) && (port_q == PortD)) || (state_q == StWr);
            if (gnt[1]) begin
                addr_q  <= bus.dAddr;
                port_q  <= PortD;
                wdata_q <= bus.dWdata;
            end else if (gnt[0]) begin
                addr_q <= bus.ifAddr;
                port_q <= PortIf;
            end
            if (state_q == StRd) begin
                if (port_q == PortIf) begin
                    if_data_q <= memData;
                end else begin
                    d_rdata_q <= memData;
                end
            end
        end
    end

    assign bus.ifGnt   = gnt[0];
    assign bus.dGnt    = gnt[1];
    assign bus.ifValid = if_valid_q;
    assign bus.dValid  = d_valid_q;
    assign bus.ifData  = if_data_q;
    assign bus.dRdata  = d_rdata_q;
    assign bus.memAddr = addr_q;
    assign bus.memRdEn = (state_q == StRd);
    assign bus.memWrEn = (state_q == StWr);

    // The RAM owns the bus in every state except WR.
    assign memData = (state_q == StWr) ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural tri-state RAM preloaded with
// mem[i] = 7*i + 3.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk;
    logic rst;
    wire  [DWIDTH-1:0] mem_data;

    mem_port_arbiter_if bus_if ();

    mem_port_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .memData (mem_data)
    );

    logic [DWIDTH-1:0] ram [MEMDEPTH];
    logic [DWIDTH-1:0] shadow [MEMDEPTH];

    assign mem_data = bus_if.memRdEn ? ram[bus_if.memAddr] : {DWIDTH{1'bz}};

    always @(posedge clk) begin
        if (bus_if.memWrEn) ram[bus_if.memAddr] = mem_data;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_miss++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // {ifGnt, dGnt, ifValid, dValid} per cycle with both ports requesting from reset
    logic [3:0] conf_exp [8] = '{4'b0100, 4'b0000, 4'b1001, 4'b0000,
                                 4'b0110, 4'b0000, 4'b1001, 4'b0000};

    logic [3:0]        obs4;
    logic              acc, val, p_we, v_we, granted, exp_g;
    logic [AWIDTH-1:0] p_addr;
    logic [DWIDTH-1:0] p_wdata, v_exp;

    initial begin
        for (int i = 0; i < MEMDEPTH; i++) begin
            ram[i]    = DWIDTH'(7 * i + 3);
            shadow[i] = DWIDTH'(7 * i + 3);
        end
        rst = 1'b1;
        bus_if.ifReq = 1'b0; bus_if.ifAddr = '0;
        bus_if.dReq = 1'b0; bus_if.dWe = 1'b0; bus_if.dAddr = '0; bus_if.dWdata = '0;
        next_cycle();

        // Reset with both requests high: nothing granted, outputs at reset values
        bus_if.ifReq = 1'b1; bus_if.dReq = 1'b1;
        @(negedge clk);
        chk("rst_if_gnt", bus_if.ifGnt, 0);
        chk("rst_d_gnt", bus_if.dGnt, 0);
        chk("rst_en", {bus_if.memRdEn, bus_if.memWrEn, bus_if.ifValid, bus_if.dValid}, 0);
        chk("rst_data", {bus_if.ifData, bus_if.dRdata}, 0);
        chk("rst_addr", bus_if.memAddr, 0);
        next_cycle();
        bus_if.ifReq = 1'b0; bus_if.dReq = 1'b0;
        rst = 1'b0;
        next_cycle();

        // Fetch from 5: mem[5] = 0x26
        bus_if.ifReq = 1'b1; bus_if.ifAddr = 6'd5;
        @(negedge clk);
        chk("fetch_gnt", {bus_if.ifGnt, bus_if.dGnt}, 2'b10);
        next_cycle();
        bus_if.ifReq = 1'b0;
        @(negedge clk);
        chk("fetch_rd", {bus_if.memRdEn, bus_if.memWrEn, bus_if.ifValid}, 3'b100);
        chk("fetch_addr", bus_if.memAddr, 5);
        chk("fetch_bus", mem_data, 8'h26);
        next_cycle();
        @(negedge clk);
        chk("fetch_valid", {bus_if.ifValid, bus_if.dValid, bus_if.memRdEn}, 3'b100);
        chk("fetch_data", bus_if.ifData, 8'h26);
        next_cycle();
        @(negedge clk);
        chk("fetch_hold", {bus_if.ifValid, bus_if.ifData, bus_if.memAddr}, {1'b0, 8'h26, 6'd5});

        // Store 0xA5 to 3, then load it back with the grant overlapping the store's dValid
        next_cycle();
        bus_if.dReq = 1'b1; bus_if.dWe = 1'b1; bus_if.dAddr = 6'd3; bus_if.dWdata = 8'hA5;
        @(negedge clk);
        chk("st_gnt", {bus_if.ifGnt, bus_if.dGnt}, 2'b01);
        next_cycle();
        bus_if.dReq = 1'b0;
        @(negedge clk);
        chk("st_wr", {bus_if.memRdEn, bus_if.memWrEn}, 2'b01);
        chk("st_bus", {bus_if.memAddr, mem_data}, {6'd3, 8'hA5});
        next_cycle();
        bus_if.dReq = 1'b1; bus_if.dWe = 1'b0; bus_if.dAddr = 6'd3;
        @(negedge clk);
        chk("st_valid", {bus_if.dValid, bus_if.dGnt, bus_if.memWrEn}, 3'b110);
        chk("st_rdata_kept", bus_if.dRdata, 0);
        shadow[3] = 8'hA5;
        next_cycle();
        bus_if.dReq = 1'b0;
        @(negedge clk);
        chk("ld_bus", {bus_if.memRdEn, mem_data}, {1'b1, 8'hA5});
        next_cycle();
        @(negedge clk);
        chk("ld_valid", {bus_if.dValid, bus_if.ifValid}, 2'b10);
        chk("ld_data", {bus_if.dRdata, bus_if.ifData}, {8'hA5, 8'h26});

        // Both ports requesting from reset: D, IF, D, IF, one grant per two cycles
        next_cycle();
        bus_if.ifReq = 1'b1; bus_if.ifAddr = 6'd5;
        bus_if.dReq = 1'b1; bus_if.dWe = 1'b0; bus_if.dAddr = 6'd3;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            obs4 = {bus_if.ifGnt, bus_if.dGnt, bus_if.ifValid, bus_if.dValid};
            chk($sformatf("conflict_c%0d", c), obs4, conf_exp[c]);
        end
        next_cycle();
        bus_if.ifReq = 1'b0; bus_if.dReq = 1'b0;
        @(negedge clk);
        chk("conflict_tail", {bus_if.ifValid, bus_if.ifData, bus_if.dRdata}, {1'b1, 8'h26, 8'hA5});
        next_cycle();
        next_cycle();

        // Random loads/stores checked against a shadow memory
        acc = 1'b0; val = 1'b0; granted = 1'b0;
        p_we = 1'b0; v_we = 1'b0; p_addr = '0; p_wdata = '0; v_exp = '0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (granted) bus_if.dReq = 1'b0;
            granted = 1'b0;
            if (!bus_if.dReq && ($urandom_range(0, 3) != 0)) begin
                bus_if.dReq   = 1'b1;
                bus_if.dWe    = 1'($urandom_range(0, 1));
                bus_if.dAddr  = 6'($urandom_range(0, 15));
                bus_if.dWdata = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            chk("rnd_excl", bus_if.memRdEn & bus_if.memWrEn, 0);
            exp_g = bus_if.dReq && !acc;
            if (val) begin
                chk("rnd_dvalid", bus_if.dValid, 1);
                if (!v_we) chk("rnd_rdata", bus_if.dRdata, v_exp);
                val = 1'b0;
            end else begin
                chk("rnd_dvalid_idle", bus_if.dValid, 0);
            end
            if (acc) begin
                chk("rnd_addr", bus_if.memAddr, p_addr);
                if (p_we) begin
                    chk("rnd_wr", {bus_if.memWrEn, bus_if.memRdEn, mem_data}, {2'b10, p_wdata});
                    shadow[p_addr] = p_wdata;
                end else begin
                    chk("rnd_rd", {bus_if.memWrEn, bus_if.memRdEn, mem_data},
                        {2'b01, shadow[p_addr]});
                end
                v_we  = p_we;
                v_exp = shadow[p_addr];
                val   = 1'b1;
                acc   = 1'b0;
            end
            chk("rnd_gnt", bus_if.dGnt, exp_g);
            if (exp_g) begin
                p_we    = bus_if.dWe;
                p_addr  = bus_if.dAddr;
                p_wdata = bus_if.dWdata;
                acc     = 1'b1;
                granted = 1'b1;
            end
        end
        next_cycle();
        bus_if.dReq = 1'b0;
        repeat (3) next_cycle();

        // Reset during RD: capture discarded, no ifValid
        bus_if.ifReq = 1'b1; bus_if.ifAddr = 6'd5;
        @(negedge clk);
        chk("rrd_gnt", bus_if.ifGnt, 1);
        next_cycle();
        bus_if.ifReq = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rrd_in_rd", bus_if.memRdEn, 1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rrd_outs", {bus_if.ifValid, bus_if.dValid, bus_if.memRdEn, bus_if.memWrEn}, 0);
        chk("rrd_regs", {bus_if.ifData, bus_if.dRdata, bus_if.memAddr}, 0);
        next_cycle();
        @(negedge clk);
        chk("rrd_no_valid", bus_if.ifValid, 0);

        // Reset during WR: write still commits, no dValid
        next_cycle();
        bus_if.dReq = 1'b1; bus_if.dWe = 1'b1; bus_if.dAddr = 6'd7; bus_if.dWdata = 8'h3C;
        @(negedge clk);
        chk("rwr_gnt", bus_if.dGnt, 1);
        next_cycle();
        bus_if.dReq = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rwr_in_wr", {bus_if.memWrEn, mem_data}, {1'b1, 8'h3C});
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rwr_no_valid", {bus_if.dValid, bus_if.memWrEn}, 0);
        next_cycle();
        bus_if.dReq = 1'b1; bus_if.dWe = 1'b0; bus_if.dAddr = 6'd7;
        @(negedge clk);
        chk("rwr_ld_gnt", bus_if.dGnt, 1);
        next_cycle();
        bus_if.dReq = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("rwr_ld_data", {bus_if.dValid, bus_if.dRdata}, {1'b1, 8'h3C});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
